// File: rtl/ssd_scan_scheduler_if.sv
// Bundle between the nibble-producing datapath and the display scan scheduler.
// The master side owns the display contents and the update request; the
// slave side (the scheduler) answers with ack/frame and drives the SSD pins.
interface ssd_scan_scheduler_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] ssd_scan_scheduler_data;
    logic [DIGITS-1:0]   ssd_scan_scheduler_en;
    logic                ssd_scan_scheduler_lzb;
    logic                ssd_scan_scheduler_upd_req;
    logic                ssd_scan_scheduler_upd_ack;
    logic                ssd_scan_scheduler_frame;
    logic [6:0]          ssd_scan_scheduler_seg;
    logic [DIGITS-1:0]   ssd_scan_scheduler_an;

    modport master (
        output ssd_scan_scheduler_data,
        output ssd_scan_scheduler_en,
        output ssd_scan_scheduler_lzb,
        output ssd_scan_scheduler_upd_req,
        input  ssd_scan_scheduler_upd_ack,
        input  ssd_scan_scheduler_frame,
        input  ssd_scan_scheduler_seg,
        input  ssd_scan_scheduler_an
    );

    modport slave (
        input  ssd_scan_scheduler_data,
        input  ssd_scan_scheduler_en,
        input  ssd_scan_scheduler_lzb,
        input  ssd_scan_scheduler_upd_req,
        output ssd_scan_scheduler_upd_ack,
        output ssd_scan_scheduler_frame,
        output ssd_scan_scheduler_seg,
        output ssd_scan_scheduler_an
    );
endinterface

// File: rtl/ssd_scan_scheduler.sv
// Seven-segment scan scheduler: walks DIGITS slots of PRESCALE cycles each,
// blanks the first BLANK cycles of every slot against ghosting, and only
// swaps in new display contents at frame boundaries via a req/ack handshake.
// All pin outputs are registered and computed from next-state values, so
// what is on the pins always matches the slot counters of the same cycle.
module ssd_scan_scheduler #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 100_000,
    parameter int BLANK    = 1
) (
    input  logic ssd_scan_scheduler_clk,
    input  logic ssd_scan_scheduler_rst,
    ssd_scan_scheduler_if.slave bus
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIGIT_MAX = DW'(DIGITS - 1);
    localparam logic [31:0]   BLANK_U   = BLANK;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

    // Slot timing and run state
    logic              run_reg;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [DW-1:0]     digit_reg, digit_next;
    logic              frame_end;
    slot_state_t       state_reg, state_next;

    // Shadow copy of the display contents, only changed at frame boundaries
    logic [4*DIGITS-1:0] shadow_data_reg, shadow_data_next;
    logic [DIGITS-1:0]   shadow_en_reg, shadow_en_next;
    logic                shadow_lzb_reg, shadow_lzb_next;
    logic                latch;

    // Registered pin drivers
    logic [6:0]          seg_reg, seg_next;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic                ack_reg;
    logic                frame_reg, frame_next;

    // Per-digit views of the next shadow contents
    logic [3:0]          nib_next [DIGITS];
    logic [DIGITS:0]     zero_from;
    logic [DIGITS-1:0]   visible;

    // Active-low hex decode, bit0 = a ... bit6 = g
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot/digit counters; the first cycle after reset release starts at slot 0
    always_comb begin
        cnt_next   = cnt_reg;
        digit_next = digit_reg;
        frame_end  = 1'b0;
        if (!run_reg) begin
            cnt_next   = '0;
            digit_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next = '0;
            if (digit_reg == DIGIT_MAX) begin
                digit_next = '0;
                frame_end  = 1'b1;
            end else begin
                digit_next = digit_reg + DW'(1);
            end
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    // Latch new contents only on the edge that closes the last frame cycle
    always_comb begin
        latch            = frame_end & bus.ssd_scan_scheduler_upd_req;
        shadow_data_next = shadow_data_reg;
        shadow_en_next   = shadow_en_reg;
        shadow_lzb_next  = shadow_lzb_reg;
        if (latch) begin
            shadow_data_next = bus.ssd_scan_scheduler_data;
            shadow_en_next   = bus.ssd_scan_scheduler_en;
            shadow_lzb_next  = bus.ssd_scan_scheduler_lzb;
        end
    end

    // Leading-zero chain: zero_from[i] is set when nibbles i..DIGITS-1 are all zero
    assign zero_from[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_next[gi]  = shadow_data_next[4*gi +: 4];
            assign zero_from[gi] = (nib_next[gi] == 4'h0) & zero_from[gi+1];
            if (gi == 0) begin : g_units
                // The units digit always shows, so an all-zero value reads "0"
                assign visible[gi] = shadow_en_next[gi];
            end else begin : g_upper
                assign visible[gi] = shadow_en_next[gi] & ~(shadow_lzb_next & zero_from[gi]);
            end
        end
    endgenerate

    // Slot FSM transition: blank window at the start of each slot, then show
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BLANK: if (32'(cnt_next) >= BLANK_U) state_next = ST_SHOW;
            ST_SHOW:  if (32'(cnt_next) <  BLANK_U) state_next = ST_BLANK;
            default:  state_next = ST_BLANK;
        endcase
    end

    // Pin values for the coming cycle, derived from next-state so no display lag
    always_comb begin
        seg_next   = 7'h7F;
        an_next    = '1;
        frame_next = (cnt_next == '0) && (digit_next == '0);
        if (state_next == ST_SHOW && visible[digit_next]) begin
            an_next[digit_next] = 1'b0;
            seg_next            = hex_decode(nib_next[digit_next]);
        end
    end

    // Single state register: counters, FSM, shadow contents and pin outputs
    always_ff @(posedge ssd_scan_scheduler_clk) begin
        if (ssd_scan_scheduler_rst) begin
            run_reg         <= 1'b0;
            cnt_reg         <= '0;
            digit_reg       <= '0;
            state_reg       <= ST_BLANK;
            shadow_data_reg <= '0;
            shadow_en_reg   <= '0;
            shadow_lzb_reg  <= 1'b0;
            seg_reg         <= 7'h7F;
            an_reg          <= '1;
            ack_reg         <= 1'b0;
            frame_reg       <= 1'b0;
        end else begin
            run_reg         <= 1'b1;
            cnt_reg         <= cnt_next;
            digit_reg       <= digit_next;
            state_reg       <= state_next;
            shadow_data_reg <= shadow_data_next;
            shadow_en_reg   <= shadow_en_next;
            shadow_lzb_reg  <= shadow_lzb_next;
            seg_reg         <= seg_next;
            an_reg          <= an_next;
            ack_reg         <= latch;
            frame_reg       <= frame_next;
        end
    end

    assign bus.ssd_scan_scheduler_seg     = seg_reg;
    assign bus.ssd_scan_scheduler_an      = an_reg;
    assign bus.ssd_scan_scheduler_upd_ack = ack_reg;
    assign bus.ssd_scan_scheduler_frame   = frame_reg;
endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler (DIGITS=8, PRESCALE=4, BLANK=1, 32-cycle frame).
// Stimulus pushes one expected frame record per upcoming frame; the monitor
// pops a record on every frame pulse and checks ack plus all 32 cycles of an/seg.
module tb_ssd_scan_scheduler;
    localparam int DIGITS   = 8;
    localparam int PRESCALE = 4;
    localparam int BLANK    = 1;
    localparam int FRAME    = DIGITS * PRESCALE;

    typedef struct packed {
        logic        ack;
        logic [7:0]  vis;
        logic [55:0] segs;   // [6:0] = digit 0
    } exp_t;

    // Hand-decoded segment patterns, digit 7 first
    localparam logic [55:0] SEG_DARK = 56'h0;
    localparam logic [55:0] SEG_A5   = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12};
    localparam logic [55:0] SEG_ZERO = {8{7'h40}};
    localparam logic [55:0] SEG_8S   = {8{7'h00}};
    localparam logic [55:0] SEG_LO   = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    localparam logic [55:0] SEG_HI   = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    ssd_scan_scheduler_if #(.DIGITS(DIGITS)) bus ();

    ssd_scan_scheduler #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE),
        .BLANK   (BLANK)
    ) dut (
        .ssd_scan_scheduler_clk(clk),
        .ssd_scan_scheduler_rst(rst),
        .bus                   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic ack, input logic [7:0] vis, input logic [55:0] segs);
        exp_t e;
        e.ack  = ack;
        e.vis  = vis;
        e.segs = segs;
        exp_q.push_back(e);
    endtask

    // Advance to the next frame-pulse cycle, bounded
    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (bus.ssd_scan_scheduler_frame === 1'b1 && !rst) seen = 1'b1;
        end
        if (!seen) check({"wait_", name}, 32'd0, 32'd1);
    endtask

    task automatic set_inputs(input logic req, input logic [31:0] data,
                              input logic [7:0] en, input logic lzb);
        bus.ssd_scan_scheduler_upd_req = req;
        bus.ssd_scan_scheduler_data    = data;
        bus.ssd_scan_scheduler_en      = en;
        bus.ssd_scan_scheduler_lzb     = lzb;
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an"},    32'(bus.ssd_scan_scheduler_an),      32'hFF);
        check({tag, "_seg"},   32'(bus.ssd_scan_scheduler_seg),     32'h7F);
        check({tag, "_ack"},   32'(bus.ssd_scan_scheduler_upd_ack), 32'h0);
        check({tag, "_frame"}, 32'(bus.ssd_scan_scheduler_frame),   32'h0);
    endtask

    // Stimulus: one step per frame, each step sets the inputs for the next boundary
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_inputs(1'b0, 32'h0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_dark("reset");
        push_exp(1'b0, 8'h00, SEG_DARK);                    // F0
        #1 rst = 1'b0;

        wait_frame("f0");
        push_exp(1'b0, 8'h00, SEG_DARK);                    // F1: no request

        wait_frame("f1");
        set_inputs(1'b1, 32'h0000_00A5, 8'hFF, 1'b0);
        push_exp(1'b1, 8'hFF, SEG_A5);                      // F2

        wait_frame("f2");
        set_inputs(1'b1, 32'h0000_00A5, 8'hFF, 1'b1);
        push_exp(1'b1, 8'h03, SEG_A5);                      // F3: leading zeros blanked

        wait_frame("f3");
        set_inputs(1'b1, 32'h0000_0000, 8'hFF, 1'b1);
        push_exp(1'b1, 8'h01, SEG_ZERO);                    // F4: only units digit

        wait_frame("f4");
        set_inputs(1'b1, 32'h8888_8888, 8'hA0, 1'b0);
        push_exp(1'b1, 8'hA0, SEG_8S);                      // F5: enable mask

        wait_frame("f5");
        set_inputs(1'b0, 32'h7654_3210, 8'hFF, 1'b0);
        push_exp(1'b0, 8'hA0, SEG_8S);                      // F6: cancelled request
        repeat (10) @(negedge clk);
        bus.ssd_scan_scheduler_upd_req = 1'b1;
        repeat (5) @(negedge clk);
        bus.ssd_scan_scheduler_upd_req = 1'b0;

        wait_frame("f6");
        set_inputs(1'b1, 32'h7654_3210, 8'hFF, 1'b0);
        push_exp(1'b1, 8'hFF, SEG_LO);                      // F7: digits 0..7

        wait_frame("f7");
        set_inputs(1'b1, 32'hFEDC_BA98, 8'hFF, 1'b0);
        push_exp(1'b1, 8'hFF, SEG_HI);                      // F8: digits 8..F

        wait_frame("f8");
        set_inputs(1'b0, 32'hFEDC_BA98, 8'hFF, 1'b0);
        push_exp(1'b0, 8'hFF, SEG_HI);                      // F9: contents persist

        wait_frame("f9");
        set_inputs(1'b1, 32'h1111_1111, 8'hFF, 1'b0);       // pending, killed by reset
        repeat (14) @(negedge clk);                         // digit 3, cnt 2
        rst = 1'b1;
        @(negedge clk);
        check_dark("midrst");
        push_exp(1'b0, 8'h00, SEG_DARK);                    // R0
        push_exp(1'b0, 8'h00, SEG_DARK);                    // R1
        #1;
        rst = 1'b0;
        set_inputs(1'b0, 32'h1111_1111, 8'hFF, 1'b0);

        wait_frame("r0");
        wait_frame("r1");
        repeat (FRAME - 1) @(negedge clk);
        @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: per frame, pop the expected record and check every cycle
    initial begin
        automatic bit         in_frame = 1'b0;
        automatic int         cyc      = 0;
        automatic int         fidx     = 0;
        automatic int         mism     = 0;
        automatic int         slot;
        automatic exp_t       cur      = '0;
        automatic logic [7:0] exp_an;
        automatic logic [6:0] exp_seg;
        automatic string      first_msg = "";
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (bus.ssd_scan_scheduler_frame === 1'b1) begin
                    if (in_frame) check("frame_period", 32'(cyc + 1), 32'(FRAME));
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                        in_frame = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check($sformatf("frame%0d_ack", fidx),
                              32'(bus.ssd_scan_scheduler_upd_ack), 32'(cur.ack));
                        cyc       = 0;
                        mism      = 0;
                        first_msg = "";
                        in_frame  = 1'b1;
                    end
                end else if (in_frame) begin
                    cyc++;
                    if (cyc == FRAME) begin
                        check("frame_late", 32'd0, 32'd1);
                        in_frame = 1'b0;
                    end
                end

                if (in_frame) begin
                    slot    = cyc / PRESCALE;
                    exp_an  = 8'hFF;
                    exp_seg = 7'h7F;
                    if ((cyc % PRESCALE) >= BLANK && cur.vis[slot]) begin
                        exp_an[slot] = 1'b0;
                        exp_seg      = cur.segs[slot*7 +: 7];
                    end
                    if (bus.ssd_scan_scheduler_an !== exp_an ||
                        bus.ssd_scan_scheduler_seg !== exp_seg ||
                        (cyc != 0 && bus.ssd_scan_scheduler_upd_ack !== 1'b0)) begin
                        if (mism == 0)
                            first_msg = $sformatf("cyc %0d an=%h seg=%b ack=%b required an=%h seg=%b ack=0",
                                                  cyc, bus.ssd_scan_scheduler_an,
                                                  bus.ssd_scan_scheduler_seg,
                                                  bus.ssd_scan_scheduler_upd_ack, exp_an, exp_seg);
                        mism++;
                    end
                    if (cyc == FRAME - 1) begin
                        total++;
                        if (mism != 0) begin
                            bad++;
                            $display("FAIL frame%0d_display: %0d bad cycles, first %s", fidx, mism, first_msg);
                        end else begin
                            $display("frame %0d ack=%b vis=%h display ok", fidx, cur.ack, cur.vis);
                        end
                        fidx++;
                    end
                end
            end
        end
    end
endmodule
